aes256_mmio_ctrl: RTL and testbench

AES256_MMIO_CTRL -- requirements
Module: aes256_mmio_ctrl

---
 rtl/aes256_mmio_ctrl_pkg.sv | 40 ++++
 rtl/aes256_mmio_ctrl_if.sv | 12 +
 rtl/aes_run_sequencer.sv | 53 +++++
 rtl/aes256_mmio_ctrl.sv | 147 ++++++++++++++
 tb/tb_aes256_mmio_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/aes256_mmio_ctrl_pkg.sv
// Shared definitions for the AES-256 MMIO controller: register map, STATUS
// field positions and run-sequencer state encoding.
package aes256_mmio_ctrl_pkg;

    localparam logic [2:0] ADDR_KEY    = 3'd0;
    localparam logic [2:0] ADDR_NONCE  = 3'd1;
    localparam logic [2:0] ADDR_DIN    = 3'd2;
    localparam logic [2:0] ADDR_DOUT   = 3'd3;
    localparam logic [2:0] ADDR_CTRL   = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int CTRL_CNTRST = 2;

    localparam int ST_FIFO_LO = 0;
    localparam int ST_OVF     = 4;
    localparam int ST_UNF     = 5;
    localparam int ST_CFG_ERR = 6;
    localparam int ST_FSM_LO  = 7;
    localparam int ST_KEY_NZ  = 9;
    localparam int ST_BLK_LO  = 16;

    typedef enum logic [1:0] {
        RUN_IDLE  = 2'd0,
        RUN_ISSUE = 2'd1,
        RUN_WAIT  = 2'd2
    } run_state_e;

    function automatic logic [31:0] pack_status(
        input logic [3:0]  fifo,
        input logic [2:0]  sticky,
        input logic [1:0]  fsm,
        input logic        key_nz,
        input logic [15:0] blk
    );
        pack_status = {blk, 6'b0, key_nz, fsm, sticky, fifo};
    endfunction

endpackage

// File: rtl/aes256_mmio_ctrl_if.sv
// Simple register bus: one access per cycle, read data returned one cycle later.
interface aes256_mmio_ctrl_if;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (output addr, wdata, we, re, input rdata, rvalid);
    modport slave  (input addr, wdata, we, re, output rdata, rvalid);
endinterface

// File: rtl/aes_run_sequencer.sv
// Block-issue sequencer: pulses run when a block is ready, then holds off for
// RUN_GAP cycles so the engine can finish before the next issue.
module aes_run_sequencer
    import aes256_mmio_ctrl_pkg::*;
#(
    parameter int RUN_GAP = 14
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        inblockfifoempty,
    input  logic        outblockfifofull,
    output logic        run_ctrout,
    output logic [1:0]  state,
    output logic [15:0] blk_cnt
);
    localparam logic [1:0] IDLE  = RUN_IDLE;
    localparam logic [1:0] ISSUE = RUN_ISSUE;
    localparam logic [1:0] WAIT  = RUN_WAIT;
    localparam int GW = (RUN_GAP > 1) ? $clog2(RUN_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(RUN_GAP - 1);

    logic [GW-1:0] gap_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            gap_cnt <= '0;
            blk_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (enable && !inblockfifoempty && !outblockfifofull) state <= ISSUE;
                ISSUE: begin
                    blk_cnt <= blk_cnt + 16'd1;
                    gap_cnt <= '0;
                    state   <= WAIT;
                end
                // The gap always runs to completion, even if enable drops meanwhile.
                WAIT: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign run_ctrout = (state == ISSUE);
endmodule

// File: rtl/aes256_mmio_ctrl.sv
// MMIO front end for an AES-256 datapath: key/nonce assembly, word FIFO
// push/pop, control/status registers and the block-issue sequencer.
module aes256_mmio_ctrl
    import aes256_mmio_ctrl_pkg::*;
#(
    parameter int RUN_GAP = 14
) (
    input  logic               clock,
    input  logic               reset,
    aes256_mmio_ctrl_if.slave  bus,
    output logic [255:0]       key_dataout,
    output logic               setkey_ctrout,
    output logic [127:0]       nonce_dataout,
    output logic               setnonce_ctrout,
    output logic               run_ctrout,
    output logic [31:0]        user_dataout,
    output logic               wren_ctrout,
    input  logic [31:0]        user_datain,
    output logic               rden_ctrout,
    input  logic               inwordfifofull,
    input  logic               inblockfifoempty,
    input  logic               outblockfifofull,
    input  logic               outwordfifoempty
);
    logic        enable, cfg_err, unf, ovf;
    logic [2:0]  key_cnt;
    logic [1:0]  nonce_cnt;
    logic [1:0]  run_state;
    logic [15:0] blk_cnt;
    logic        rvalid_q, dout_sel_q;
    logic [31:0] rdata_q, rd_mux, status_w;

    // A cycle with both strobes high is a write.
    wire wr        = bus.we;
    wire rd        = bus.re && !bus.we;
    wire wr_key    = wr && (bus.addr == ADDR_KEY);
    wire wr_nonce  = wr && (bus.addr == ADDR_NONCE);
    wire wr_din    = wr && (bus.addr == ADDR_DIN);
    wire wr_ctrl   = wr && (bus.addr == ADDR_CTRL);
    wire rd_dout   = rd && (bus.addr == ADDR_DOUT);
    wire key_ld    = wr_key && !enable;
    wire nonce_ld  = wr_nonce && !enable;
    wire din_push  = wr_din && !inwordfifofull;
    wire dout_pop  = rd_dout && !outwordfifoempty;
    wire clr_stky  = wr_ctrl && bus.wdata[CTRL_CLEAR];
    wire cnt_rst   = wr_ctrl && bus.wdata[CTRL_CNTRST];

    assign rden_ctrout = dout_pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_dataout     <= '0;
            nonce_dataout   <= '0;
            key_cnt         <= '0;
            nonce_cnt       <= '0;
            setkey_ctrout   <= 1'b0;
            setnonce_ctrout <= 1'b0;
        end else begin
            setkey_ctrout   <= 1'b0;
            setnonce_ctrout <= 1'b0;
            if (cnt_rst) begin
                key_cnt   <= '0;
                nonce_cnt <= '0;
            end
            if (key_ld) begin
                for (int k = 0; k < 8; k++)
                    if (key_cnt == 3'(k)) key_dataout[255-32*k -: 32] <= bus.wdata;
                key_cnt       <= key_cnt + 3'd1;
                setkey_ctrout <= (key_cnt == 3'd7);
            end
            if (nonce_ld) begin
                for (int k = 0; k < 4; k++)
                    if (nonce_cnt == 2'(k)) nonce_dataout[127-32*k -: 32] <= bus.wdata;
                nonce_cnt       <= nonce_cnt + 2'd1;
                setnonce_ctrout <= (nonce_cnt == 2'd3);
            end
        end
    end

    // Sticky flags: a set in the same cycle as a clear takes priority.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enable  <= 1'b0;
            cfg_err <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else begin
            if (wr_ctrl) enable <= bus.wdata[CTRL_ENABLE];
            if ((wr_key || wr_nonce) && enable) cfg_err <= 1'b1;
            else if (clr_stky)                  cfg_err <= 1'b0;
            if (wr_din && inwordfifofull)       ovf <= 1'b1;
            else if (clr_stky)                  ovf <= 1'b0;
            if (rd_dout && outwordfifoempty)    unf <= 1'b1;
            else if (clr_stky)                  unf <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            user_dataout <= '0;
            wren_ctrout  <= 1'b0;
        end else begin
            wren_ctrout <= din_push;
            if (din_push) user_dataout <= bus.wdata;
        end
    end

    assign status_w = pack_status({outwordfifoempty, outblockfifofull, inblockfifoempty, inwordfifofull},
                                  {cfg_err, unf, ovf}, run_state, (key_cnt != 3'd0), blk_cnt);

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            ADDR_CTRL:   rd_mux = {31'b0, enable};
            ADDR_STATUS: rd_mux = status_w;
            default:     rd_mux = '0;
        endcase
    end

    // DOUT data comes from the datapath the cycle after the pop, so it is
    // muxed in live rather than captured at the access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            dout_sel_q <= 1'b0;
        end else begin
            rvalid_q   <= rd;
            rdata_q    <= rd ? rd_mux : 32'd0;
            dout_sel_q <= dout_pop;
        end
    end

    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = dout_sel_q ? user_datain : rdata_q;

    aes_run_sequencer #(.RUN_GAP(RUN_GAP)) u_seq (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .inblockfifoempty (inblockfifoempty),
        .outblockfifofull (outblockfifofull),
        .run_ctrout       (run_ctrout),
        .state            (run_state),
        .blk_cnt          (blk_cnt)
    );
endmodule

// File: tb/tb_aes256_mmio_ctrl.sv
// Directed bench for aes256_mmio_ctrl; read results go through a scoreboard queue.
module tb_aes256_mmio_ctrl;
    logic         clock = 1'b0;
    logic         reset;
    logic [255:0] key_dataout;
    logic [127:0] nonce_dataout;
    logic         setkey_ctrout, setnonce_ctrout, run_ctrout, wren_ctrout, rden_ctrout;
    logic [31:0]  user_dataout, user_datain;
    logic         inwordfifofull, inblockfifoempty, outblockfifofull, outwordfifoempty;

    aes256_mmio_ctrl_if bus();

    aes256_mmio_ctrl #(.RUN_GAP(14)) dut (
        .clock            (clock),
        .reset            (reset),
        .bus              (bus),
        .key_dataout      (key_dataout),
        .setkey_ctrout    (setkey_ctrout),
        .nonce_dataout    (nonce_dataout),
        .setnonce_ctrout  (setnonce_ctrout),
        .run_ctrout       (run_ctrout),
        .user_dataout     (user_dataout),
        .wren_ctrout      (wren_ctrout),
        .user_datain      (user_datain),
        .rden_ctrout      (rden_ctrout),
        .inwordfifofull   (inwordfifofull),
        .inblockfifoempty (inblockfifoempty),
        .outblockfifofull (outblockfifofull),
        .outwordfifoempty (outwordfifoempty)
    );

    always #5 clock = ~clock;

    int errors = 0, checks = 0, cyc = 0;
    int n_setkey = 0, n_setnonce = 0, n_run = 0;
    int run_t[$];
    logic [31:0] sb[$];

    always @(posedge clock) cyc++;
    always @(negedge clock) begin
        if (setkey_ctrout)   n_setkey++;
        if (setnonce_ctrout) n_setnonce++;
        if (run_ctrout) begin
            n_run++;
            run_t.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected STATUS built from the bench's own view of inputs and flags.
    function automatic logic [31:0] st(input bit ovf, input bit unf, input bit cfg,
                                       input bit keynz, input logic [15:0] blk);
        st = {blk, 6'b0, keynz, 2'b00, cfg, unf, ovf,
              outwordfifoempty, outblockfifofull, inblockfifoempty, inwordfifofull};
    endfunction

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clock);
        bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        @(negedge clock);
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input logic exp_rden, input string tag);
        sb.push_back(exp);
        @(negedge clock);
        bus.re = 1'b1; bus.addr = a;
        #1 chk({tag, "_rden"}, 256'(rden_ctrout), 256'(exp_rden));
        @(negedge clock);
        bus.re = 1'b0;
        chk({tag, "_rvalid"}, 256'(bus.rvalid), 256'd1);
        chk({tag, "_rdata"}, 256'(bus.rdata), 256'(sb.pop_front()));
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    logic [255:0] ek;
    logic [127:0] en;
    int base;

    initial begin
        reset = 1'b1;
        bus.we = 1'b0; bus.re = 1'b0; bus.addr = '0; bus.wdata = '0;
        user_datain = '0;
        inwordfifofull = 1'b0; inblockfifoempty = 1'b1;
        outblockfifofull = 1'b0; outwordfifoempty = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_key", key_dataout, '0);
        chk("reset_nonce", 256'(nonce_dataout), '0);
        chk("reset_ctl", 256'({setkey_ctrout, setnonce_ctrout, run_ctrout, wren_ctrout,
                               rden_ctrout, bus.rvalid}), '0);
        chk("reset_data", 256'({bus.rdata, user_dataout}), '0);
        reset = 1'b0;
        rd(3'd5, st(0, 0, 0, 0, 16'd0), 1'b0, "status_reset");

        // Full key load, MSW first
        for (int k = 0; k < 7; k++) wr(3'd0, 32'(k + 1));
        chk("setkey_early", 256'(setkey_ctrout), 256'd0);
        wr(3'd0, 32'd8);
        chk("setkey_pulse", 256'(setkey_ctrout), 256'd1);
        @(negedge clock);
        chk("setkey_once", 256'(setkey_ctrout), 256'd0);
        for (int k = 0; k < 8; k++) ek[255-32*k -: 32] = 32'(k + 1);
        chk("key_value", key_dataout, ek);
        chk("setkey_count", 256'(n_setkey), 256'd1);
        rd(3'd5, st(0, 0, 0, 0, 16'd0), 1'b0, "status_keywrap");

        // Nonce load with enable low
        en = {32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
        for (int k = 0; k < 4; k++) wr(3'd1, en[127-32*k -: 32]);
        chk("setnonce_pulse", 256'(setnonce_ctrout), 256'd1);
        chk("nonce_value", 256'(nonce_dataout), 256'(en));

        // Nonce writes while enabled are dropped
        wr(3'd4, 32'd1);
        rd(3'd4, 32'd1, 1'b0, "ctrl_en");
        for (int k = 0; k < 4; k++) wr(3'd1, 32'(32'h11 + k));
        repeat (2) @(negedge clock);
        chk("setnonce_blocked", 256'(n_setnonce), 256'd1);
        chk("nonce_kept", 256'(nonce_dataout), 256'(en));
        rd(3'd5, st(0, 0, 1, 0, 16'd0), 1'b0, "status_cfgerr");
        wr(3'd4, 32'd3);
        rd(3'd5, st(0, 0, 0, 0, 16'd0), 1'b0, "status_cfgclr");
        rd(3'd4, 32'd1, 1'b0, "ctrl_en_kept");
        wr(3'd4, 32'd0);

        // DIN push and overflow
        wr(3'd2, 32'hCAFE0001);
        chk("din_wren", 256'({wren_ctrout, user_dataout}), 256'({1'b1, 32'hCAFE0001}));
        @(negedge clock);
        chk("din_wren_once", 256'(wren_ctrout), 256'd0);
        inwordfifofull = 1'b1;
        wr(3'd2, 32'hDEAD0002);
        chk("din_ovf_nowren", 256'(wren_ctrout), 256'd0);
        rd(3'd5, st(1, 0, 0, 0, 16'd0), 1'b0, "status_ovf");
        inwordfifofull = 1'b0;

        // DOUT underflow, then a real pop
        rd(3'd3, 32'd0, 1'b0, "dout_empty");
        rd(3'd5, st(1, 1, 0, 0, 16'd0), 1'b0, "status_unf");
        outwordfifoempty = 1'b0;
        user_datain = 32'h5A5A1234;
        rd(3'd3, 32'h5A5A1234, 1'b1, "dout_pop");
        outwordfifoempty = 1'b1;
        rd(3'd6, 32'd0, 1'b0, "unmapped_rd");
        wr(3'd7, 32'hFFFFFFFF);
        wr(3'd4, 32'd2);
        rd(3'd5, st(0, 0, 0, 0, 16'd0), 1'b0, "status_clr");

        // Run sequencing: three pulses 16 cycles apart in a 40-cycle window
        inblockfifoempty = 1'b0;
        wr(3'd4, 32'd1);
        repeat (40) @(negedge clock);
        inblockfifoempty = 1'b1;
        wr(3'd4, 32'd0);
        repeat (20) @(negedge clock);
        chk("run_count", 256'(n_run), 256'd3);
        if (run_t.size() >= 3) begin
            chk("run_gap1", 256'(run_t[1] - run_t[0]), 256'd16);
            chk("run_gap2", 256'(run_t[2] - run_t[1]), 256'd16);
        end
        rd(3'd5, st(0, 0, 0, 0, 16'd3), 1'b0, "status_blk");

        // Reset in the middle of a key load
        for (int k = 0; k < 5; k++) wr(3'd0, 32'(32'h100 + k));
        rd(3'd5, st(0, 0, 0, 1, 16'd3), 1'b0, "status_keynz");
        pulse_reset();
        chk("key_after_rst", key_dataout, '0);
        rd(3'd5, st(0, 0, 0, 0, 16'd0), 1'b0, "status_after_rst");
        base = n_setkey;
        for (int k = 0; k < 8; k++) wr(3'd0, 32'(32'hA0 + k));
        repeat (2) @(negedge clock);
        chk("setkey_post_rst", 256'(n_setkey - base), 256'd1);
        for (int k = 0; k < 8; k++) ek[255-32*k -: 32] = 32'(32'hA0 + k);
        chk("key_post_rst", key_dataout, ek);

        // CTRL counter reset restarts the key at word 0
        for (int k = 0; k < 3; k++) wr(3'd0, 32'(32'h300 + k));
        wr(3'd4, 32'd4);
        rd(3'd5, st(0, 0, 0, 0, 16'd0), 1'b0, "status_cntrst");
        base = n_setkey;
        for (int k = 0; k < 8; k++) wr(3'd0, 32'(32'hB0 + k));
        repeat (2) @(negedge clock);
        chk("setkey_cntrst", 256'(n_setkey - base), 256'd1);
        for (int k = 0; k < 8; k++) ek[255-32*k -: 32] = 32'(32'hB0 + k);
        chk("key_cntrst", key_dataout, ek);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
